// File: rtl/npu_cube_pkg.sv
// Shared helpers for the NPU cube MAC datapath.
// Purpose: derived-width functions (clog2, adder-tree result width) and the
// partial-product extension/shift function. The MAC-array wrapper reuses them.
// No ports (package).
package npu_cube_pkg;

    // Working width for the generic extend/shift helper. Callers cast the
    // result down to their own width.
    localparam int MAX_W = 128;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

    // Result width of the pairwise tree: operand width, plus the largest
    // per-index shift, plus one carry bit per level.
    function automatic int sum_width(input int pp_w, input int pp_num, input int shift_step);
        return pp_w + shift_step * (pp_num - 1) + clog2(pp_num);
    endfunction

    // Extend the low w bits of v (sign or zero) to MAX_W, then shift left.
    // Extending before shifting gives the same low bits as extending to the
    // final width first, so the caller only has to truncate.
    function automatic logic [MAX_W-1:0] ext_shift(input logic [MAX_W-1:0] v,
                                                   input int w,
                                                   input logic sgn,
                                                   input int shamt);
        logic [MAX_W-1:0] r;
        logic             fill;
        fill = sgn & v[w-1];
        for (int b = 0; b < MAX_W; b++) begin
            r[b] = (b < w) ? v[b] : fill;
        end
        return r << shamt;
    endfunction

endpackage

// File: rtl/npu_cube_add_level.sv
// One registered pairwise-add level of the partial-product tree.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_en              pipeline enable (global stall when 0)
//   i_valid/i_signed/i_first/i_last  sideband in
//   i_data            N operands of W bits, operand j at [W*(j+1)-1 : W*j]
//   o_valid/o_signed/o_first/o_last  registered sideband out
//   o_data            N/2 registered sums, out[j] = in[2j] + in[2j+1] mod 2^W
module npu_cube_add_level
    import npu_cube_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_valid,
    input  logic                 i_signed,
    input  logic                 i_first,
    input  logic                 i_last,
    input  logic [N*W-1:0]       i_data,
    output logic                 o_valid,
    output logic                 o_signed,
    output logic                 o_first,
    output logic                 o_last,
    output logic [(N/2)*W-1:0]   o_data
);

    localparam int NO = N / 2;

    logic [NO*W-1:0] w_sum;
    logic [NO*W-1:0] r_data;
    logic            r_valid;
    logic            r_signed;
    logic            r_first;
    logic            r_last;

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < NO; j++) begin
            w_sum[j*W +: W] = i_data[(2*j)*W +: W] + i_data[(2*j+1)*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_signed <= 1'b0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
        end else if (i_en) begin
            r_data   <= w_sum;
            r_valid  <= i_valid;
            r_signed <= i_signed;
            r_first  <= i_first;
            r_last   <= i_last;
        end
    end

    assign o_data   = r_data;
    assign o_valid  = r_valid;
    assign o_signed = r_signed;
    assign o_first  = r_first;
    assign o_last   = r_last;

endmodule

// File: rtl/npu_cube_pp_add_tree.sv
// Pipelined partial-product adder tree with burst accumulator.
// Purpose: extend/shift PP_NUM partial products, sum them through LVL
// registered pairwise levels, then accumulate tree results across a
// first/last-delimited burst; emit the accumulated value on last beats.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   in_valid/in_ready, in_data, in_signed, in_first, in_last   input beat
//   out_valid/out_ready, out_data                              result
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready = !out_valid || out_ready, which also freezes every pipeline
// register while the output is held.
module npu_cube_pp_add_tree
    import npu_cube_pkg::*;
#(
    parameter int PP_W       = 11,
    parameter int PP_NUM     = 8,
    parameter int SHIFT_STEP = 0,
    parameter int ACC_W      = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PP_W*PP_NUM-1:0] in_data,
    input  logic                   in_signed,
    input  logic                   in_first,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_data
);

    localparam int LVL   = clog2(PP_NUM);
    localparam int SUM_W = sum_width(PP_W, PP_NUM, SHIFT_STEP);

    logic                    w_en;
    logic [PP_NUM*SUM_W-1:0] w_ext;
    logic [SUM_W-1:0]        w_tree_sum;
    logic                    w_tree_valid;
    logic                    w_tree_signed;
    logic                    w_tree_first;
    logic                    w_tree_last;
    logic [ACC_W-1:0]        w_sum_ext;
    logic [ACC_W-1:0]        w_acc_next;
    logic [ACC_W-1:0]        r_acc;
    logic                    r_out_valid;

    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    // Extend each partial product to SUM_W and apply its index shift.
    for (genvar i = 0; i < PP_NUM; i++) begin : g_ext
        assign w_ext[i*SUM_W +: SUM_W] =
            SUM_W'(ext_shift(MAX_W'(in_data[i*PP_W +: PP_W]), PP_W, in_signed, i * SHIFT_STEP));
    end

    for (genvar k = 0; k < LVL; k++) begin : g_lvl
        localparam int NK = PP_NUM >> k;
        logic [NK*SUM_W-1:0]     w_in;
        logic [(NK/2)*SUM_W-1:0] w_out;
        logic w_in_valid, w_in_signed, w_in_first, w_in_last;
        logic w_out_valid, w_out_signed, w_out_first, w_out_last;

        if (k == 0) begin : g_head
            assign w_in        = w_ext;
            assign w_in_valid  = in_valid;
            assign w_in_signed = in_signed;
            assign w_in_first  = in_first;
            assign w_in_last   = in_last;
        end else begin : g_chain
            assign w_in        = g_lvl[k-1].w_out;
            assign w_in_valid  = g_lvl[k-1].w_out_valid;
            assign w_in_signed = g_lvl[k-1].w_out_signed;
            assign w_in_first  = g_lvl[k-1].w_out_first;
            assign w_in_last   = g_lvl[k-1].w_out_last;
        end

        npu_cube_add_level #(
            .N (NK),
            .W (SUM_W)
        ) u_level (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_en     (w_en),
            .i_valid  (w_in_valid),
            .i_signed (w_in_signed),
            .i_first  (w_in_first),
            .i_last   (w_in_last),
            .i_data   (w_in),
            .o_valid  (w_out_valid),
            .o_signed (w_out_signed),
            .o_first  (w_out_first),
            .o_last   (w_out_last),
            .o_data   (w_out)
        );
    end

    assign w_tree_sum    = g_lvl[LVL-1].w_out;
    assign w_tree_valid  = g_lvl[LVL-1].w_out_valid;
    assign w_tree_signed = g_lvl[LVL-1].w_out_signed;
    assign w_tree_first  = g_lvl[LVL-1].w_out_first;
    assign w_tree_last   = g_lvl[LVL-1].w_out_last;

    // Each beat's tree result is widened per that beat's own signed flag.
    assign w_sum_ext  = ACC_W'(ext_shift(MAX_W'(w_tree_sum), SUM_W, w_tree_signed, 0));
    assign w_acc_next = w_tree_first ? w_sum_ext : (r_acc + w_sum_ext);

    // The accumulator doubles as the output register: it only changes on a
    // valid tree slot while enabled, so it holds while the output is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            if (w_tree_valid) begin
                r_acc <= w_acc_next;
            end
            r_out_valid <= w_tree_valid & w_tree_last;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_acc;

endmodule

// File: tb/tb_npu_cube_pp_add_tree.sv
// Bench for npu_cube_pp_add_tree: a default-parameter instance plus a
// shifted-operand instance (PP_W=5, PP_NUM=4, SHIFT_STEP=2). Drivers push
// hand-computed results into expected queues; monitors pop on each output
// handshake.
module tb_npu_cube_pp_add_tree;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [87:0] in_data;
    logic        in_signed;
    logic        in_first;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;

    logic        s2_in_valid;
    logic        s2_in_ready;
    logic [19:0] s2_in_data;
    logic        s2_in_signed;
    logic        s2_in_first;
    logic        s2_in_last;
    logic        s2_out_valid;
    logic        s2_out_ready;
    logic [23:0] s2_out_data;

    logic [23:0] exp_q[$];
    logic [23:0] exp2_q[$];

    int checks;
    int failures;

    npu_cube_pp_add_tree u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    npu_cube_pp_add_tree #(
        .PP_W       (5),
        .PP_NUM     (4),
        .SHIFT_STEP (2),
        .ACC_W      (24)
    ) u_dut_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s2_in_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_in_data),
        .in_signed (s2_in_signed),
        .in_first  (s2_in_first),
        .in_last   (s2_in_last),
        .out_valid (s2_out_valid),
        .out_ready (s2_out_ready),
        .out_data  (s2_out_data)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [87:0] d, input logic sg, input logic f,
                             input logic l, input logic [23:0] exp);
        int n;
        n = 0;
        in_data   = d;
        in_signed = sg;
        in_first  = f;
        in_last   = l;
        in_valid  = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
        end else if (l) begin
            exp_q.push_back(exp);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send2(input logic [19:0] d, input logic sg, input logic [23:0] exp);
        int n;
        n = 0;
        s2_in_data   = d;
        s2_in_signed = sg;
        s2_in_first  = 1'b1;
        s2_in_last   = 1'b1;
        s2_in_valid  = 1'b1;
        #1;
        while (!s2_in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!s2_in_ready) begin
            checks++;
            failures++;
            $display("FAIL send2_timeout actual=in_ready_low required=in_ready_high");
        end else begin
            exp2_q.push_back(exp);
        end
        @(negedge clk);
        s2_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        logic [23:0] e;
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_unexpected actual=0x%0h required=no_output", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", {8'h0, out_data}, {8'h0, e});
            end
        end
    end

    always @(negedge clk) begin
        logic [23:0] e;
        #2;
        if (rst_n && s2_out_valid && s2_out_ready) begin
            if (exp2_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL shift_out_unexpected actual=0x%0h required=no_output", s2_out_data);
            end else begin
                e = exp2_q.pop_front();
                chk("shift_out_data", {8'h0, s2_out_data}, {8'h0, e});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_signed    = 1'b0;
        in_first     = 1'b0;
        in_last      = 1'b0;
        out_ready    = 1'b1;
        s2_in_valid  = 1'b0;
        s2_in_data   = '0;
        s2_in_signed = 1'b0;
        s2_in_first  = 1'b0;
        s2_in_last   = 1'b0;
        s2_out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_out_data", {8'h0, out_data}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", {31'h0, in_ready}, 32'h1);

        // Unsigned all-max single beat, with latency measurement
        send_beat({8{11'h7FF}}, 1'b0, 1'b1, 1'b1, 24'h003FF8);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency_cycles", n + 1, 32'd4);
        idle(2);

        // Signed vs unsigned of the same data, then signed negative sum
        send_beat({{7{11'h001}}, 11'h7FF}, 1'b1, 1'b1, 1'b1, 24'h000006);
        send_beat({{7{11'h001}}, 11'h7FF}, 1'b0, 1'b1, 1'b1, 24'h000806);
        send_beat({8{11'h7FF}}, 1'b1, 1'b1, 1'b1, 24'hFFFFF8);
        drain();

        // Three-beat burst with bubbles: one output only
        send_beat({8{11'h001}}, 1'b0, 1'b1, 1'b0, 24'h0);
        idle(1);
        send_beat({8{11'h001}}, 1'b0, 1'b0, 1'b0, 24'h0);
        idle(2);
        send_beat({8{11'h001}}, 1'b0, 1'b0, 1'b1, 24'd24);
        drain();

        // Mixed-sign burst: -1 (signed) then 2047 (unsigned) = 2046
        send_beat({{7{11'h000}}, 11'h7FF}, 1'b1, 1'b1, 1'b0, 24'h0);
        send_beat({{7{11'h000}}, 11'h7FF}, 1'b0, 1'b0, 1'b1, 24'h0007FE);
        drain();

        // Output stall with four results in flight
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send_beat({8{11'(k)}}, 1'b0, 1'b1, 1'b1, 24'(8 * k));
        end
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
            chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
            chk("stall_out_data", {8'h0, out_data}, 32'd8);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();

        // Reset mid-burst, then a fresh single-beat burst
        send_beat({8{11'h005}}, 1'b0, 1'b1, 1'b0, 24'h0);
        send_beat({8{11'h005}}, 1'b0, 1'b0, 1'b0, 24'h0);
        rst_n = 1'b0;
        idle(2);
        chk("midreset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midreset_out_data", {8'h0, out_data}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_in_ready", {31'h0, in_ready}, 32'h1);
        send_beat({8{11'h002}}, 1'b0, 1'b1, 1'b1, 24'd16);
        drain();

        // first=0 straight after reset accumulates onto zero
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat({8{11'h001}}, 1'b0, 1'b0, 1'b1, 24'd8);
        drain();

        // Shifted-operand instance: 1+4+16+64 and its signed negation
        send2({4{5'h01}}, 1'b0, 24'd85);
        send2({4{5'h1F}}, 1'b1, 24'hFFFFAB);
        drain();

        idle(4);
        chk("exp_q_empty", exp_q.size(), 32'd0);
        chk("exp2_q_empty", exp2_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npu_cube_pp_add_tree.md
# npu_cube_pp_add_tree

Pipelined, parametrised partial-product adder tree for the NPU cube MAC datapath. It replaces the single-cycle 8-way combinational sum with a registered binary tree that has configurable operand count, width, per-index shift and signed/unsigned extension. A trailing accumulator stage sums consecutive tree results across a first/last-delimited burst. It sits between the Booth partial-product generator and the cube result buffer, with a valid/ready handshake on both sides.

## Interface
- PP_W, 11, width of one partial product (2*operand width + 1)
- PP_NUM, 8, number of partial products per beat; power of two, 2..32
- SHIFT_STEP, 0, left shift applied to index i is i*SHIFT_STEP bits (0 = pre-aligned operands)
- LVL, log2(PP_NUM), derived, tree depth
- SUM_W, PP_W + SHIFT_STEP*(PP_NUM-1) + LVL, derived, tree result width
- ACC_W, 24, accumulator/output width; must be >= SUM_W
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  PP_W*PP_NUM  packed partial products; pp[i] = in_data[PP_W*(i+1)-1 : PP_W*i]
- in_signed  in  1  1: sign-extend each pp; 0: zero-extend
- in_first  in  1  beat starts a new accumulation
- in_last  in  1  beat ends the accumulation; result emitted
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts
- out_data  out  ACC_W  accumulated result, sign-/zero-extended per in_signed of the last beat

## Operation
- Extension: each pp extended to SUM_W per in_signed, then shifted left by i*SHIFT_STEP; bits above SUM_W discarded.
- Tree: LVL levels; level k adds adjacent pairs of level k-1 and registers them. All arithmetic is modulo 2^SUM_W (two's complement in signed mode).
- Sideband (valid, signed, first, last) travels alongside the data through every level.
- Accumulator stage: on a valid tree output, first=1 loads acc = ext(sum); otherwise acc = acc + ext(sum), modulo 2^ACC_W. ext() extends SUM_W to ACC_W per that beat's signed bit.
- out_valid rises only for beats with last=1; out_data = the updated acc value. first=last=1 gives a plain per-beat sum (legacy behaviour).
- A beat with first=0 and no prior open burst after reset accumulates onto acc reset value 0.
- No internal state machine beyond the open/closed burst implied by first/last; mixed in_signed within a burst is legal, with each beat extended per its own flag.

## Timing
- Reset (rst_n=0 at posedge): all valid bits 0, acc 0, all tree registers 0, out_valid 0, out_data 0. in_ready is 1 on the cycle after reset is released. Reset mid-burst discards the burst; the next beat must carry first=1 for a defined result.
- Global stall: en = !out_valid || out_ready; in_ready = en. When en=0 no pipeline register (tree, sideband, acc, output) changes.
- Latency: LVL+1 cycles from acceptance of a last beat to out_valid (default 4), with no stall.
- Throughput: one beat per cycle while out_ready=1; bubbles (in_valid=0) propagate as invalid slots and never alter acc.
- out_data/out_valid hold stable while out_valid && !out_ready.
- Simultaneous output handshake and new tree result in the same cycle: output reloads in that cycle with no bubble.

## Structure
- A shared package npu_cube_pkg holds the derived-width functions (clog2, SUM_W computation) and the pp extension/shift function, so they can be reused by the MAC-array wrapper.
- One sub-module, npu_cube_add_level: a single registered pairwise-add level (N inputs -> N/2 outputs, sideband pass-through, enable). Instantiate it LVL times in a generate loop; the accumulator/output stage stays in the top.

## Test plan
- Defaults, unsigned, first=last=1, all pp=0x7FF -> out_data=0x3FF8 exactly 4 cycles after acceptance.
- Signed, first=last=1, pp[0]=0x7FF (-1), others 0x001 -> out_data=6 (0x000006); the same data unsigned -> 0x0806.
- 3-beat burst (first on beat 0, last on beat 2), each beat all pp=1 -> a single out_valid with out_data=24; no output on beats 0 and 1.
- out_ready held 0 for 5 cycles with 4 beats in flight -> in_ready=0, out_data stable, and all 4 results are delivered in order once released with none lost.
- SHIFT_STEP=2, PP_NUM=4, PP_W=5, unsigned, pp={1,1,1,1} -> 1+4+16+64=85.
- Reset asserted mid-burst, then a new burst of first=last=1 with pp all 2 -> out_data=16, with no residue from the aborted burst.
